// File: rtl/shift_register_sequencer.sv
// shift_register_sequencer: command-driven front end that streams or loads a word into a downstream ShiftRegister
module shift_register_sequencer #(
    parameter int N = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] Data,
    input  logic [1:0]   Command,
    output logic [1:0]   Status,
    output logic         W,
    output logic [N-1:0] P,
    output logic         Busy,
    output logic         Done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;
    state_t         state_q, state_d;
    logic [N-1:0]   buf_q, buf_d, p_q, p_d;
    logic [CW-1:0]  count_q, count_d, nxt;
    logic [1:0]     status_q, status_d;
    logic           dir_q, dir_d, w_q, w_d, busy_q, busy_d, done_q, done_d;
    assign Status = status_q;
    assign W      = w_q;
    assign P      = p_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign nxt    = count_q + CW'(1);
    // Next-state and next-output computation; dir_q high means MSB-first (left) streaming
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        dir_d    = dir_q;
        count_d  = count_q;
        status_d = status_q;
        w_d      = w_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            IDLE: if (Command != 2'd0) begin
                buf_d  = Data;
                dir_d  = (Command == 2'd2);
                busy_d = 1'b1;
                status_d = Command;
                if (Command == 2'd3) begin
                    state_d = LOAD;
                    p_d     = Data;
                end else begin
                    state_d = SHIFT;
                    w_d     = (Command == 2'd1) ? Data[0] : Data[N-1];
                    count_d = '0;
                end
            end
            SHIFT: if (count_q == CW'(N-1)) begin
                state_d  = DONE;
                status_d = 2'd0;
                w_d      = 1'b0;
                done_d   = 1'b1;
            end else begin
                count_d = nxt;
                w_d     = dir_q ? buf_q[CW'(N-1) - nxt] : buf_q[nxt];
            end
            LOAD: begin
                state_d  = DONE;
                status_d = 2'd0;
                p_d      = '0;
                done_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end
    // State and output registers; reset aborts any transfer in progress
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            dir_q    <= 1'b0;
            count_q  <= '0;
            status_q <= 2'd0;
            w_q      <= 1'b0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
            status_q <= status_d;
            w_q      <= w_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_shift_register_sequencer.sv
// tb_shift_register_sequencer: scoreboard bench for shift_register_sequencer with N=4
module tb_shift_register_sequencer;
    logic       Clock = 1'b0;
    logic       Reset, W, Busy, Done;
    logic [3:0] Data, P;
    logic [1:0] Command, Status;
    logic       mon_en = 1'b0;
    logic [8:0] q[$];
    int         checks = 0;
    int         errors = 0;

    shift_register_sequencer #(.N(4)) dut (
        .Clock(Clock), .Reset(Reset), .Data(Data), .Command(Command),
        .Status(Status), .W(W), .P(P), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // Expected output vector {Status, W, P, Busy, Done} for one cycle
    task automatic exp(input logic [1:0] st, input logic w, input logic [3:0] p,
                       input logic busy, input logic done);
        q.push_back({st, w, p, busy, done});
    endtask

    // Monitor: every cycle pops one expected vector, or checks idle zeros when none is pending
    initial begin
        logic [8:0] act, e;
        forever begin
            @(posedge Clock);
            #1;
            if (mon_en) begin
                act = {Status, W, P, Busy, Done};
                checks++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL xfer: got {st,w,p,busy,done}=%b want %b at %0t", act, e, $time);
                    end
                end else if (act !== 9'b0) begin
                    errors++;
                    $display("FAIL idle: got {st,w,p,busy,done}=%b want 000000000 at %0t", act, $time);
                end
            end
        end
    end

    initial begin
        // 1: reset with a pending command
        Reset = 1'b1; Command = 2'd1; Data = 4'b1111;
        @(posedge Clock);
        #2 mon_en = 1'b1;
        @(negedge Clock);
        Command = 2'd0; Reset = 1'b0;
        repeat (2) @(negedge Clock);
        // 2: serial right 1101 -> W 1,0,1,1
        Command = 2'd1; Data = 4'b1101;
        exp(1, 1, 0, 1, 0); exp(1, 0, 0, 1, 0); exp(1, 1, 0, 1, 0); exp(1, 1, 0, 1, 0);
        exp(0, 0, 0, 1, 1);
        @(negedge Clock); Command = 2'd0; Data = 4'b0000;
        repeat (6) @(negedge Clock);
        // 3: serial left 1101 -> W 1,1,0,1
        Command = 2'd2; Data = 4'b1101;
        exp(2, 1, 0, 1, 0); exp(2, 1, 0, 1, 0); exp(2, 0, 0, 1, 0); exp(2, 1, 0, 1, 0);
        exp(0, 0, 0, 1, 1);
        @(negedge Clock); Command = 2'd0;
        repeat (6) @(negedge Clock);
        // 4: parallel load 1001
        Command = 2'd3; Data = 4'b1001;
        exp(3, 0, 4'b1001, 1, 0); exp(0, 0, 0, 1, 1);
        @(negedge Clock); Command = 2'd0; Data = 4'b0000;
        repeat (3) @(negedge Clock);
        // 5: serial right 0110 with Command=2/Data=0000 held during the transfer
        Command = 2'd1; Data = 4'b0110;
        exp(1, 0, 0, 1, 0); exp(1, 1, 0, 1, 0); exp(1, 1, 0, 1, 0); exp(1, 0, 0, 1, 0);
        exp(0, 0, 0, 1, 1);
        @(negedge Clock); Command = 2'd2; Data = 4'b0000;
        repeat (5) @(negedge Clock);
        Command = 2'd0;
        repeat (3) @(negedge Clock);
        // 6: reset during the second shift cycle, then a load
        Command = 2'd1; Data = 4'b1010;
        exp(1, 0, 0, 1, 0); exp(1, 1, 0, 1, 0);
        @(negedge Clock); Command = 2'd0;
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock); Reset = 1'b0;
        repeat (3) @(negedge Clock);
        Command = 2'd3; Data = 4'b0101;
        exp(3, 0, 4'b0101, 1, 0); exp(0, 0, 0, 1, 1);
        @(negedge Clock); Command = 2'd0;
        repeat (4) @(negedge Clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
